weight_update_pipe: RTL and testbench

//  Consumes the weight-update address stream and applies w <= w - lr*grad to the

---
 rtl/weight_update_pipe.sv | 256 +++++++++++++++++++++++++
 tb/tb_weight_update_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_pipe.sv
// -----------------------------------------------------------------------------
// weight_update_pipe
//
// Applies w <= w - lr*grad to the weight RAM for every beat of the
// weight-update address stream, as a 3-stage read-modify-write pipeline.
// Accepts one beat per cycle, counts the beats of a pass and pulses o_done
// once the last write has left the pipeline.
//
// Optional feature macro: WU_SAT_EN
//   defined   : the updated weight is clamped to the DATA_WIDTH signed range,
//               and each clamp increments o_sat_cnt
//   undefined : the low DATA_WIDTH bits are written (two's-complement wrap),
//               and o_sat_cnt is tied to 0
//
// Ports
//   clk, rst    clock (rising edge), synchronous active-high reset
//   i_start     starts a pass; only sampled while idle
//   i_valid     i_addr / i_grad carry a beat this cycle
//   i_addr      weight address
//   i_grad      signed gradient for i_addr
//   i_lr        signed learning rate, stable for the whole pass
//   o_rd_addr   RAM read address (combinational copy of i_addr)
//   i_rd_data   RAM read data, one cycle after o_rd_addr
//   o_wr_en     RAM write strobe
//   o_wr_addr   RAM write address
//   o_wr_data   updated weight
//   o_busy      pass in progress (RUN or DRAIN)
//   o_done      one-cycle pulse at the end of a pass
//   o_sat_cnt   saturation events in the current pass
// -----------------------------------------------------------------------------
module weight_update_pipe #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC        = 12,
  parameter int NUM_WEIGHTS = 2809
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_valid,
  input  logic        [ADDR_WIDTH-1:0] i_addr,
  input  logic signed [DATA_WIDTH-1:0] i_grad,
  input  logic signed [DATA_WIDTH-1:0] i_lr,
  output logic        [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] i_rd_data,
  output logic                         o_wr_en,
  output logic        [ADDR_WIDTH-1:0] o_wr_addr,
  output logic signed [DATA_WIDTH-1:0] o_wr_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic        [15:0]           o_sat_cnt
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(NUM_WEIGHTS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_WEIGHTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  // lr*grad scaled back to weight format; >>> truncates toward -inf.
  function automatic logic signed [PW-1:0] scaled_delta(
    input logic signed [DATA_WIDTH-1:0] grad,
    input logic signed [DATA_WIDTH-1:0] lr
  );
    logic signed [PW-1:0] prod;
    prod = PW'(grad) * PW'(lr);
    return prod >>> FRAC;
  endfunction

  function automatic logic signed [PW-1:0] full_sum(
    input logic signed [DATA_WIDTH-1:0] w,
    input logic signed [DATA_WIDTH-1:0] grad,
    input logic signed [DATA_WIDTH-1:0] lr
  );
    return PW'(w) - scaled_delta(grad, lr);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] wrap_to_w(
    input logic signed [PW-1:0] s
  );
    return s[DATA_WIDTH-1:0];
  endfunction

`ifdef WU_SAT_EN
  // The value fits when all bits above the weight's sign bit copy it.
  function automatic logic overflows(input logic signed [PW-1:0] s);
    return !((&s[PW-1:DATA_WIDTH-1]) || !(|s[PW-1:DATA_WIDTH-1]));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] clamp_to_w(
    input logic signed [PW-1:0] s
  );
    if (!overflows(s))
      return wrap_to_w(s);
    else if (s[PW-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction
`endif

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    beat_cnt;
  logic                accept;
  logic                start_pass;

  logic                         vld_p0, vld_p1, vld_p2, vld_p3;
  logic        [ADDR_WIDTH-1:0] addr_p0, addr_p1, addr_p2, addr_p3;
  logic signed [DATA_WIDTH-1:0] grad_p0, grad_p1;
  logic signed [DATA_WIDTH-1:0] w_p1, data_p2, data_p3;
  logic signed [DATA_WIDTH-1:0] w_fwd, sum_w;

  assign accept     = (state == RUN) && i_valid;
  assign start_pass = (state == IDLE) && i_start;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (accept && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
      // The last write is registered on the edge that sees S0/S1 empty.
      DRAIN:   if (!vld_p0 && !vld_p1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             beat_cnt <= '0;
    else if (start_pass) beat_cnt <= '0;
    else if (accept)     beat_cnt <= beat_cnt + CNT_W'(1);
  end

  assign o_busy    = (state == RUN) || (state == DRAIN);
  assign o_done    = (state == DONE);
  assign o_rd_addr = i_addr;

  // ---------------------------------------------------------------------------
  // S0: read issued combinationally, capture address and gradient
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= i_addr;
      grad_p0 <= i_grad;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: capture read data, forwarding any newer in-flight result
  // ---------------------------------------------------------------------------
  // The RAM returns pre-write data for any update still in S2, in the write
  // register, or written on the same edge as the read (vld_p3). Later checks
  // override earlier ones so the youngest matching result wins.
  always_comb begin
    w_fwd = i_rd_data;
    if (vld_p3 && (addr_p3 == addr_p0)) w_fwd = data_p3;
    if (vld_p2 && (addr_p2 == addr_p0)) w_fwd = data_p2;
    if (vld_p1 && (addr_p1 == addr_p0)) w_fwd = sum_w;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      addr_p1 <= addr_p0;
      grad_p1 <= grad_p0;
      w_p1    <= w_fwd;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: compute the updated weight and register the write
  // ---------------------------------------------------------------------------
`ifdef WU_SAT_EN
  logic signed [PW-1:0] sum_full;
  logic                 sum_ovf;

  always_comb begin
    sum_full = full_sum(w_p1, grad_p1, i_lr);
    sum_w    = clamp_to_w(sum_full);
    sum_ovf  = overflows(sum_full);
  end

  logic [15:0] sat_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt <= '0;
    else if (start_pass)
      sat_cnt <= '0;
    else if (vld_p1 && sum_ovf && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end

  assign o_sat_cnt = sat_cnt;
`else
  always_comb sum_w = wrap_to_w(full_sum(w_p1, grad_p1, i_lr));

  assign o_sat_cnt = '0;
`endif

  // Write register drives the RAM ports, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        addr_p2 <= addr_p1;
        data_p2 <= sum_w;
      end
    end
  end

  assign o_wr_en   = vld_p2;
  assign o_wr_addr = addr_p2;
  assign o_wr_data = data_p2;

  // ---------------------------------------------------------------------------
  // P3: copy of the write just committed, kept for one more cycle for
  //     read-before-write RAMs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) vld_p3 <= 1'b0;
    else     vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    if (vld_p2) begin
      addr_p3 <= addr_p2;
      data_p3 <= data_p2;
    end
  end

endmodule

// File: tb/tb_weight_update_pipe.sv
module tb_weight_update_pipe;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int FR = 12;
  localparam int NW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic                 i_valid;
  logic        [AW-1:0] i_addr;
  logic signed [DW-1:0] i_grad;
  logic signed [DW-1:0] i_lr;
  logic        [AW-1:0] o_rd_addr;
  logic signed [DW-1:0] i_rd_data;
  logic                 o_wr_en;
  logic        [AW-1:0] o_wr_addr;
  logic signed [DW-1:0] o_wr_data;
  logic                 o_busy;
  logic                 o_done;
  logic        [15:0]   o_sat_cnt;

  always #5 clk = ~clk;

  weight_update_pipe #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FRAC       (FR),
    .NUM_WEIGHTS(NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_grad   (i_grad),
    .i_lr     (i_lr),
    .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data),
    .o_wr_en  (o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_sat_cnt(o_sat_cnt)
  );

  // Weight RAM: one-cycle read latency, read returns the old value when the
  // same address is written on the same edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)       mem[pre_addr]  <= pre_data;
    else if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
    i_rd_data <= mem[o_rd_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (o_wr_en) begin
      w.a = o_wr_addr;
      w.d = o_wr_data;
      w.c = cyc;
      obs_q.push_back(w);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference model state: sequential semantics of w <= w - lr*grad.
  int ref_mem [0:15];
  int ref_save[0:15];
  int total = 0;
  int bad = 0;
  int exp_sat = 0;
  int pass_cnt = 0;
  int done_base = 0;
  int lr_cur = 0;
  bit running = 1'b0;

  `define CHK(tag, obs, exp) \
    begin \
      total++; \
      assert ((obs) === (exp)) else begin \
        bad++; \
        $error("FAIL %s: got %0h want %0h", tag, (obs), (exp)); \
      end \
    end

  function automatic longint floor_div(longint p);
    longint q;
    longint scale;
    scale = longint'(1) << FR;
    q = p / scale;
    if (p < 0 && q * scale != p) q = q - 1;
    return q;
  endfunction

  task automatic ram_set(int a, int v);
    logic signed [DW-1:0] t;
    t = DW'(v);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = t;
    @(negedge clk);
    pre_we   = 1'b0;
    ref_mem[a] = int'(t);
  endtask

  task automatic start_pass(int lr);
    i_start = 1'b1;
    i_lr    = DW'(lr);
    @(negedge clk);
    i_start   = 1'b0;
    running   = 1'b1;
    pass_cnt  = 0;
    exp_sat   = 0;
    lr_cur    = lr;
    done_base = done_cnt;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic beat(int a, int g);
    int     acc;
    longint s;
    wr_t    e;
    i_valid = 1'b1;
    i_addr  = AW'(a);
    i_grad  = DW'(g);
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    i_valid = 1'b0;
    if (running && pass_cnt < NW) begin
      s = longint'(ref_mem[a]) - floor_div(longint'(g) * longint'(lr_cur));
`ifdef WU_SAT_EN
      if (s > 32767) begin
        s = 32767;
        if (exp_sat < 65535) exp_sat++;
      end else if (s < -32768) begin
        s = -32768;
        if (exp_sat < 65535) exp_sat++;
      end
`else
      s = ((s % 65536) + 65536) % 65536;
      if (s > 32767) s = s - 65536;
`endif
      ref_mem[a] = int'(s);
      e.a = AW'(a);
      e.d = DW'(s);
      e.c = acc + 2;
      exp_q.push_back(e);
      pass_cnt++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_pass();
    int lim;
    int last;
    lim = 0;
    while (done_cnt == done_base && lim < 60) begin
      @(negedge clk);
      lim++;
    end
    idle(2);
    `CHK("done_once", done_cnt, done_base + 1)
    last = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].c : 0;
    `CHK("done_time", done_cyc, last + 1)
    `CHK("wr_count", obs_q.size(), exp_q.size())
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      assert (obs_q[i].a === exp_q[i].a && obs_q[i].d === exp_q[i].d &&
              obs_q[i].c === exp_q[i].c)
      else begin
        bad++;
        $error("FAIL wr[%0d]: got a=%0h d=%0h c=%0d want a=%0h d=%0h c=%0d",
               i, obs_q[i].a, obs_q[i].d, obs_q[i].c,
               exp_q[i].a, exp_q[i].d, exp_q[i].c);
      end
    end
    `CHK("busy_after", o_busy, 1'b0)
    `CHK("sat_cnt", o_sat_cnt, 16'(exp_sat))
    running = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_addr  = '0;
    i_grad  = '0;
    i_lr    = '0;
    idle(3);

    // Reset state
    `CHK("rst_wr_en", o_wr_en, 1'b0)
    `CHK("rst_wr_addr", o_wr_addr, 12'h000)
    `CHK("rst_wr_data", o_wr_data, 16'sh0000)
    `CHK("rst_busy", o_busy, 1'b0)
    `CHK("rst_done", o_done, 1'b0)
    `CHK("rst_sat", o_sat_cnt, 16'h0000)
    rst = 1'b0;
    idle(1);

    for (int a = 0; a < 16; a++)
      ram_set(a, int'($urandom_range(0, 65535)) - 32768);

    // Basic update and back-to-back same-address forwarding
    ram_set(5, 'h1000);
    ram_set(3, 'h1000);
    ram_set(6, 'h0100);
    start_pass('h0400);
    `CHK("busy_run", o_busy, 1'b1)
    beat(5, 'h0800);
    beat(3, 'h0800);
    beat(3, 'h0800);
    beat(6, 'h0100);
    finish_pass();
    `CHK("basic_addr", obs_q[0].a, 12'h005)
    `CHK("basic_data", obs_q[0].d, 16'h0E00)
    `CHK("fwd_first", obs_q[1].d, 16'h0E00)
    `CHK("fwd_second", obs_q[2].d, 16'h0C00)

    // Bubbles between beats
    start_pass('h0400);
    beat(0, 'h0100);
    beat(1, 'h0200);
    idle(2);
    beat(2, 'h0300);
    beat(3, 'h0400);
    finish_pass();
    `CHK("bubble_gap", obs_q[2].c - obs_q[1].c, 3)

    // Ignored inputs: valid while idle, start while running; saturation
    obs_q.delete();
    beat(9, 'h0100);
    beat(10, 'h0100);
    idle(4);
    `CHK("idle_no_wr", obs_q.size(), 0)
    ram_set(0, 'h7F00);
    start_pass('h1000);
    beat(0, -32768);
    pulse_start();
    beat(1, 'h0010);
    pulse_start();
    beat(2, 'h0020);
    beat(3, 'h0030);
    finish_pass();
`ifdef WU_SAT_EN
    `CHK("sat_data", obs_q[0].d, 16'h7FFF)
    `CHK("sat_count", o_sat_cnt, 16'h0001)
`else
    `CHK("wrap_data", obs_q[0].d, 16'hFF00)
    `CHK("wrap_count", o_sat_cnt, 16'h0000)
`endif

    // Reset mid-pass abandons the in-flight beats
    ref_save = ref_mem;
    start_pass('h0400);
    beat(1, 'h0100);
    beat(2, 'h0100);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    running = 1'b0;
    ref_mem = ref_save;
    exp_q.delete();
    idle(5);
    `CHK("rst_mid_no_wr", obs_q.size(), 0)
    `CHK("rst_mid_no_done", done_cnt, done_base)
    `CHK("rst_mid_idle", o_busy, 1'b0)
    `CHK("rst_mid_wr_en", o_wr_en, 1'b0)
    start_pass('h0400);
    beat(1, 'h0100);
    beat(2, 'h0100);
    beat(1, 'h0200);
    beat(4, 'h0300);
    finish_pass();

    // Randomized passes with bubbles and an extra beat past the end
    for (int p = 0; p < 4; p++) begin
      start_pass(int'($urandom_range(0, 65535)) - 32768);
      for (int b = 0; b < NW + 1; b++) begin
        beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)) - 32768);
        idle(int'($urandom_range(0, 3)));
      end
      finish_pass();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
